// File: rtl/seg_cmd_pkg.sv
// Shared widths, opcodes and FSM state type for the segmented-command scheduler.
package seg_cmd_pkg;

    localparam int D1_W      = 8;
    localparam int D2_W      = 8;
    localparam int D3_W      = 6;
    localparam int D4_W      = 7;
    localparam int D5_W      = 12;
    localparam int PAYLOAD_W = D1_W + D2_W + D3_W + D4_W + D5_W;
    localparam int SEL_W     = 4;
    localparam int ENTRY_W   = SEL_W + PAYLOAD_W;

    localparam logic [SEL_W-1:0] FLUSH_OP = 4'hF;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

endpackage

// File: rtl/seg_cmd_fifo.sv
// Synchronous FIFO holding {state_sel, payload} entries; flush empties it in one cycle.
module seg_cmd_fifo #(
    parameter int WIDTH = 45,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: an entry is only ever read after it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/seg_cmd_scheduler.sv
// Queues segmented commands and dispatches them one at a time to NUM_TGT targets
// over valid/ready, dropping illegal, overflowing and timed-out commands.
module seg_cmd_scheduler
    import seg_cmd_pkg::*;
#(
    parameter int NUM_TGT = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 seg_done,
    input  logic                 en,
    input  logic [SEL_W-1:0]     state_sel,
    input  logic [D1_W-1:0]      data1,
    input  logic [D2_W-1:0]      data2,
    input  logic [D3_W-1:0]      data3,
    input  logic [D4_W-1:0]      data4,
    input  logic [D5_W-1:0]      data5,
    output logic                 out_valid,
    output logic [SEL_W-1:0]     out_tgt,
    output logic [PAYLOAD_W-1:0] out_payload,
    input  logic [NUM_TGT-1:0]   out_ready,
    output logic                 busy,
    output logic                 fifo_full,
    output logic                 err_illegal,
    output logic                 err_overflow,
    output logic                 err_timeout,
    output logic [7:0]           drop_cnt
);

    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [SEL_W:0]   NUM_TGT_L = 5'(NUM_TGT);

    state_t                 state_q, state_d;
    logic [SEL_W-1:0]       out_tgt_q, out_tgt_d;
    logic [PAYLOAD_W-1:0]   out_payload_q, out_payload_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;
    logic                   err_illegal_q, err_illegal_d;
    logic                   err_overflow_q, err_overflow_d;
    logic                   err_timeout_q, err_timeout_d;

    logic                   cmd_valid;
    logic                   sel_legal;
    logic                   is_flush;
    logic                   is_illegal;
    logic                   is_overflow;
    logic                   do_push;
    logic                   do_pop;
    logic                   timeout_hit;
    logic                   ready_sel;
    logic                   fifo_empty;
    logic [ENTRY_W-1:0]     fifo_head;
    logic [8:0]             drop_sum;

    assign cmd_valid   = seg_done && en;
    assign sel_legal   = ({1'b0, state_sel} < NUM_TGT_L);
    assign is_flush    = cmd_valid && (state_sel == FLUSH_OP);
    assign is_illegal  = cmd_valid && !sel_legal && (state_sel != FLUSH_OP);
    assign is_overflow = cmd_valid && sel_legal && fifo_full;
    assign do_push     = cmd_valid && sel_legal && !fifo_full;

    seg_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (do_push),
        .pop   (do_pop),
        .flush (is_flush),
        .wdata ({state_sel, data1, data2, data3, data4, data5}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Only the addressed target's ready bit takes part in the handshake.
    always_comb begin
        ready_sel = 1'b0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (out_tgt_q == SEL_W'(i)) begin
                ready_sel = out_ready[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        out_tgt_d     = out_tgt_q;
        out_payload_d = out_payload_q;
        to_cnt_d      = to_cnt_q;
        do_pop        = 1'b0;
        timeout_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !is_flush) begin
                    do_pop        = 1'b1;
                    out_tgt_d     = fifo_head[ENTRY_W-1 -: SEL_W];
                    out_payload_d = fifo_head[PAYLOAD_W-1:0];
                    to_cnt_d      = '0;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (ready_sel) begin
                    state_d = IDLE;
                end else if (to_cnt_q == TO_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A push drop and a timeout abort can land on the same edge, so up to +2.
    always_comb begin
        err_illegal_d  = is_illegal;
        err_overflow_d = is_overflow;
        err_timeout_d  = timeout_hit;
        drop_sum       = {1'b0, drop_cnt_q} + 9'(is_illegal) + 9'(is_overflow) + 9'(timeout_hit);
        drop_cnt_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            out_tgt_q      <= '0;
            out_payload_q  <= '0;
            to_cnt_q       <= '0;
            drop_cnt_q     <= '0;
            err_illegal_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            out_tgt_q      <= out_tgt_d;
            out_payload_q  <= out_payload_d;
            to_cnt_q       <= to_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            err_illegal_q  <= err_illegal_d;
            err_overflow_q <= err_overflow_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign out_valid    = (state_q == ISSUE);
    assign out_tgt      = out_tgt_q;
    assign out_payload  = out_payload_q;
    assign busy         = !fifo_empty || (state_q != IDLE);
    assign err_illegal  = err_illegal_q;
    assign err_overflow = err_overflow_q;
    assign err_timeout  = err_timeout_q;
    assign drop_cnt     = drop_cnt_q;

endmodule
